// File: rtl/cdb_broadcast.sv
// Common-data-bus writeback stage: one holding slot per execution unit, one broadcast per cycle.
// Define CDB_RR_EN for round-robin arbitration; otherwise fixed priority, highest unit index first.
module cdb_broadcast #(
    parameter int N_UNITS = 3,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      cdb_stall,
    input  logic [N_UNITS-1:0]        eu_valid,
    input  logic [N_UNITS*TAG_W-1:0]  eu_tag,
    input  logic [N_UNITS*DATA_W-1:0] eu_value,
    output logic [N_UNITS-1:0]        eu_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_value,
    output logic [1:0]                cdb_unit,
    output logic [15:0]               bcast_cnt
);

    logic [N_UNITS-1:0] r_hv;
    logic [TAG_W-1:0]   r_ht [N_UNITS];
    logic [DATA_W-1:0]  r_hd [N_UNITS];

    logic               r_cdb_valid;
    logic [TAG_W-1:0]   r_cdb_tag;
    logic [DATA_W-1:0]  r_cdb_value;
    logic [1:0]         r_cdb_unit;
    logic [15:0]        r_bcast_cnt;

    logic               w_any;
    logic [1:0]         w_gidx;
    logic [N_UNITS-1:0] w_grant;
    logic [N_UNITS-1:0] w_cap;
    logic [N_UNITS-1:0] w_hv_next;

    // Any occupied slot may be granted unless the bus is blocked this cycle.
    assign w_any = (|r_hv) && !cdb_stall && !flush && !rst;

`ifdef CDB_RR_EN
    logic [1:0] r_ptr;

    // Scan from the pointer upward with wrap; iterating backwards lets the first hit win.
    always_comb begin
        int idx;
        idx    = 0;
        w_gidx = 2'd0;
        for (int k = N_UNITS - 1; k >= 0; k--) begin
            idx = int'(r_ptr) + k;
            if (idx >= N_UNITS) begin
                idx = idx - N_UNITS;
            end
            if (r_hv[idx]) begin
                w_gidx = 2'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 2'd0;
        end else if (w_any) begin
            r_ptr <= (w_gidx == 2'(N_UNITS - 1)) ? 2'd0 : w_gidx + 2'd1;
        end
    end
`else
    // Ascending scan: the highest occupied index overwrites lower ones.
    always_comb begin
        w_gidx = 2'd0;
        for (int u = 0; u < N_UNITS; u++) begin
            if (r_hv[u]) begin
                w_gidx = 2'(u);
            end
        end
    end
`endif

    assign w_grant   = w_any ? (N_UNITS'(1) << w_gidx) : '0;
    assign eu_ready  = flush ? '0 : (~r_hv | w_grant);
    assign w_cap     = eu_valid & eu_ready;
    assign w_hv_next = (r_hv & ~w_grant) | w_cap;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_hv <= '0;
        end else begin
            r_hv <= w_hv_next;
        end
        for (int u = 0; u < N_UNITS; u++) begin
            if (w_cap[u]) begin
                r_ht[u] <= eu_tag[u*TAG_W +: TAG_W];
                r_hd[u] <= eu_value[u*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_value <= '0;
            r_cdb_unit  <= 2'd0;
            r_bcast_cnt <= 16'd0;
        end else begin
            r_cdb_valid <= w_any;
            if (w_any) begin
                r_cdb_tag   <= r_ht[w_gidx];
                r_cdb_value <= r_hd[w_gidx];
                r_cdb_unit  <= w_gidx;
                if (r_bcast_cnt != 16'hFFFF) begin
                    r_bcast_cnt <= r_bcast_cnt + 16'd1;
                end
            end
        end
    end

    assign cdb_valid = r_cdb_valid;
    assign cdb_tag   = r_cdb_tag;
    assign cdb_value = r_cdb_value;
    assign cdb_unit  = r_cdb_unit;
    assign bcast_cnt = r_bcast_cnt;

endmodule

// File: tb/tb_cdb_broadcast.sv
// Scoreboarded bench for cdb_broadcast: directed stimulus pushes expected broadcasts, a monitor pops them.
module tb_cdb_broadcast;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        cdb_stall;
    logic [2:0]  eu_valid;
    logic [11:0] eu_tag;
    logic [95:0] eu_value;
    logic [2:0]  eu_ready;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic [1:0]  cdb_unit;
    logic [15:0] bcast_cnt;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] val;
        logic [1:0]  unit;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_cnt = 0;
    bit   quiet = 0;

`ifdef CDB_RR_EN
    localparam logic [2:0] COLL_R1 = 3'b001;
    localparam logic [2:0] COLL_R2 = 3'b011;
`else
    localparam logic [2:0] COLL_R1 = 3'b100;
    localparam logic [2:0] COLL_R2 = 3'b110;
`endif

    cdb_broadcast #(.N_UNITS(3), .DATA_W(32), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .cdb_stall(cdb_stall),
        .eu_valid(eu_valid), .eu_tag(eu_tag), .eu_value(eu_value),
        .eu_ready(eu_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value), .cdb_unit(cdb_unit), .bcast_cnt(bcast_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic set_eu(input int u, input logic [3:0] tag, input logic [31:0] val);
        eu_valid[u]         = 1'b1;
        eu_tag[u*4 +: 4]    = tag;
        eu_value[u*32 +: 32] = val;
    endtask

    task automatic push(input logic [3:0] tag, input logic [31:0] val, input logic [1:0] unit);
        exp_t e;
        e.tag  = tag;
        e.val  = val;
        e.unit = unit;
        q.push_back(e);
        exp_cnt++;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    // Monitor: every presented broadcast must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cdb_valid === 1'b1) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_bcast: got tag %0h unit %0d, required no broadcast", cdb_tag, cdb_unit);
                end else begin
                    e = q.pop_front();
                    check("bcast_tag", 64'(cdb_tag), 64'(e.tag));
                    check("bcast_value", 64'(cdb_value), 64'(e.val));
                    check("bcast_unit", 64'(cdb_unit), 64'(e.unit));
                    if (!quiet) begin
                        $display("bcast: tag=%0h value=%0h unit=%0d cnt=%0d", cdb_tag, cdb_value, cdb_unit, bcast_cnt);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; cdb_stall = 1'b0;
        eu_valid = '0; eu_tag = '0; eu_value = '0;
        repeat (3) tick();
        rst = 1'b0;
        samp();
        check("rst_valid", 64'(cdb_valid), 64'd0);
        check("rst_tag", 64'(cdb_tag), 64'd0);
        check("rst_value", 64'(cdb_value), 64'd0);
        check("rst_unit", 64'(cdb_unit), 64'd0);
        check("rst_cnt", 64'(bcast_cnt), 64'd0);
        check("rst_ready", 64'(eu_ready), 64'h7);

        // Single result from unit 0
        tick(); set_eu(0, 4'h3, 32'h10); push(4'h3, 32'h10, 2'd0);
        tick(); eu_valid = '0;
        repeat (3) tick();
        samp();
        check("single_cnt", 64'(bcast_cnt), 64'd1);

        // Three-way collision from a fresh pointer
        do_reset();
        tick();
        set_eu(0, 4'h1, 32'd100); set_eu(1, 4'h2, 32'd200); set_eu(2, 4'h3, 32'd300);
`ifdef CDB_RR_EN
        push(4'h1, 32'd100, 2'd0); push(4'h2, 32'd200, 2'd1); push(4'h3, 32'd300, 2'd2);
`else
        push(4'h3, 32'd300, 2'd2); push(4'h2, 32'd200, 2'd1); push(4'h1, 32'd100, 2'd0);
`endif
        tick(); eu_valid = '0;
        samp(); check("coll_ready1", 64'(eu_ready), 64'(COLL_R1));
        tick(); samp(); check("coll_ready2", 64'(eu_ready), 64'(COLL_R2));
        tick(); samp(); check("coll_ready3", 64'(eu_ready), 64'h7);
        repeat (2) tick();

        // Back-to-back refill of unit 2
        for (int i = 0; i < 4; i++) begin
            tick();
            set_eu(2, 4'(5 + i), 32'h50 + 32'(i));
            push(4'(5 + i), 32'h50 + 32'(i), 2'd2);
            samp();
            check("b2b_ready2", 64'(eu_ready[2]), 64'd1);
            if (i >= 2) check("b2b_valid", 64'(cdb_valid), 64'd1);
        end
        tick(); eu_valid = '0;
        samp(); check("b2b_valid", 64'(cdb_valid), 64'd1);
        tick(); samp(); check("b2b_valid", 64'(cdb_valid), 64'd1);
        tick(); samp(); check("b2b_idle", 64'(cdb_valid), 64'd0);

        // Stall for five cycles while every unit delivers one result
        tick();
        cdb_stall = 1'b1;
        set_eu(0, 4'hA, 32'hA0); set_eu(1, 4'hB, 32'hB0); set_eu(2, 4'hC, 32'hC0);
`ifdef CDB_RR_EN
        push(4'hA, 32'hA0, 2'd0); push(4'hB, 32'hB0, 2'd1); push(4'hC, 32'hC0, 2'd2);
`else
        push(4'hC, 32'hC0, 2'd2); push(4'hB, 32'hB0, 2'd1); push(4'hA, 32'hA0, 2'd0);
`endif
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) eu_valid = '0;
            if (k == 5) cdb_stall = 1'b0;
            samp();
            check("stall_valid", 64'(cdb_valid), 64'd0);
            if (k < 5) check("stall_ready", 64'(eu_ready), 64'd0);
        end
        for (int j = 0; j < 3; j++) begin
            tick(); samp();
            check("stall_release_valid", 64'(cdb_valid), 64'd1);
        end
        tick(); samp(); check("stall_release_idle", 64'(cdb_valid), 64'd0);

        // Flush while slots hold tags 1 and 2 and unit 2 offers tag 9
        tick();
        cdb_stall = 1'b1;
        set_eu(0, 4'h1, 32'd11); set_eu(1, 4'h2, 32'd22);
        tick();
        eu_valid = '0;
        flush = 1'b1;
        set_eu(2, 4'h9, 32'd99);
        samp(); check("flush_ready", 64'(eu_ready), 64'd0);
        tick();
        flush = 1'b0; eu_valid = '0; cdb_stall = 1'b0;
        samp();
        check("post_flush_ready", 64'(eu_ready), 64'h7);
        check("post_flush_valid", 64'(cdb_valid), 64'd0);
        repeat (3) begin
            tick(); samp();
            check("post_flush_valid", 64'(cdb_valid), 64'd0);
        end
        check("flush_cnt", 64'(bcast_cnt), 64'(exp_cnt));

        // Reset while all slots are full
        tick();
        cdb_stall = 1'b1;
        set_eu(0, 4'h4, 32'h44); set_eu(1, 4'h5, 32'h55); set_eu(2, 4'h6, 32'h66);
        tick(); eu_valid = '0;
        samp(); check("full_ready", 64'(eu_ready), 64'd0);
        tick(); rst = 1'b1; cdb_stall = 1'b0;
        tick(); rst = 1'b0; exp_cnt = 0;
        samp();
        check("midrst_valid", 64'(cdb_valid), 64'd0);
        check("midrst_tag", 64'(cdb_tag), 64'd0);
        check("midrst_value", 64'(cdb_value), 64'd0);
        check("midrst_unit", 64'(cdb_unit), 64'd0);
        check("midrst_cnt", 64'(bcast_cnt), 64'd0);
        check("midrst_ready", 64'(eu_ready), 64'h7);
        tick(); samp(); check("midrst_no_pulse", 64'(cdb_valid), 64'd0);

        // Saturation: more than 65535 broadcasts from unit 0
        quiet = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            tick();
            set_eu(0, 4'(i), 32'(i));
            push(4'(i), 32'(i), 2'd0);
        end
        tick(); eu_valid = '0;
        repeat (4) tick();
        samp();
        check("sat_cnt", 64'(bcast_cnt), 64'hFFFF);
        quiet = 1'b0;
        $display("saturation: bcast_cnt=%0h after %0d broadcasts", bcast_cnt, exp_cnt);

        check("queue_empty", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cdb_broadcast.md
# cdb_broadcast

Result writeback stage of the Tomasulo core: captures finished results from the execution units (two add/sub units, one mul/div unit), buffers one result per unit, and arbitrates a single broadcast per cycle onto the common data bus (CDB). Reservation stations and the register status table snoop the CDB. A unit's holding slot is freed when its result is broadcast, which lets that unit present its next result.

## Interface
Parameters:
- N_UNITS, 3: number of execution units. Units 0 and 1 are add/sub; unit N_UNITS-1 is mul/div.
- DATA_W, 32: result width.
- TAG_W, 4: reservation-station tag width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- flush  in  1  synchronous discard of all buffered and in-flight results.
- cdb_stall  in  1  downstream cannot accept a broadcast this cycle.
- eu_valid  in  N_UNITS  per-unit result present.
- eu_tag  in  N_UNITS*TAG_W  per-unit result tag; unit u occupies bits [u*TAG_W +: TAG_W].
- eu_value  in  N_UNITS*DATA_W  per-unit result value; same packing as eu_tag.
- eu_ready  out  N_UNITS  per-unit holding slot can accept a result this cycle.
- cdb_valid  out  1  broadcast valid; high for exactly one cycle per result.
- cdb_tag  out  TAG_W  broadcast tag.
- cdb_value  out  DATA_W  broadcast value.
- cdb_unit  out  2  index of the source unit.
- bcast_cnt  out  16  total broadcasts since reset; saturates at 16'hFFFF.

## Operation
- Each unit u has one holding slot: hv[u] (valid), ht[u] (tag), hd[u] (value).
- Capture: result u is captured when eu_valid[u] && eu_ready[u] at a rising edge; hv[u] is set and tag/value are stored.
- eu_ready[u] = !hv[u] || grant[u]. This is combinational, so a granted slot can be refilled on the same edge it drains.
- A result with eu_valid[u] && !eu_ready[u] is not captured. The unit holds eu_valid, eu_tag and eu_value stable until it is accepted.
- Arbitration is combinational over hv[]. grant is one-hot or zero.
- When cdb_stall=1, flush=1 or rst=1, grant is zero.
- On a grant to unit g:
  - cdb_valid, cdb_tag, cdb_value and cdb_unit register ht[g], hd[g] and g at the next edge.
  - hv[g] clears at that edge unless it is refilled on the same edge.
- With no grant, cdb_valid=0 next cycle. cdb_tag, cdb_value and cdb_unit hold their last values.
- bcast_cnt increments on each edge where cdb_valid is loaded to 1, saturating at 16'hFFFF.
- Flush:
  - hv[] clears and cdb_valid=0 at the next edge.
  - Results offered in the flush cycle are dropped; eu_ready is forced to 0 while flush=1.
  - bcast_cnt and the arbiter pointer are unchanged.
- Priority of events: rst > flush > cdb_stall > normal.

## Timing
- Reset values: cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_unit=0, bcast_cnt=0, hv[]=0, arbiter pointer=0. After reset, eu_ready is all ones.
- Latency: a result captured at edge E appears with cdb_valid=1 in the cycle after edge E+1 at the earliest (one cycle buffered).
- Throughput: one broadcast per cycle overall. A single unit refilled every cycle sustains one result per cycle while it wins arbitration.
- Contention: losers keep their slots, and eu_ready stays low for units whose slot is occupied and not granted.
- Stall:
  - While stalled, slots fill but do not drain.
  - When all slots are full, eu_ready is all zeros.
  - The first cycle after the stall is released, the arbiter grants according to the current pointer.
- Reset mid-operation: all buffered results are lost. No cdb_valid pulse occurs in the cycle after reset.

## Configuration
- CDB_RR_EN defined: round-robin arbitration.
  - The search starts at pointer p and wraps around through N_UNITS-1 and 0.
  - After a grant to unit g, p becomes (g+1) mod N_UNITS.
  - p does not change when there is no grant.
- CDB_RR_EN undefined: fixed priority, highest index first, so mul/div beats unit 1, which beats unit 0. The pointer logic is absent.

## Test plan
- Single result: after reset, unit 0 presents tag 4'h3, value 32'h0000_0010 for one cycle -> captured, then a single cdb_valid pulse with cdb_tag=3, cdb_value=16, cdb_unit=0; bcast_cnt=1.
- Three-way collision: units 0/1/2 present tags 1/2/3 on the same edge.
  - With CDB_RR_EN: broadcasts in order units 0, 1, 2 on three consecutive cycles.
  - Without CDB_RR_EN: order 2, 1, 0.
  - In both cases eu_ready[loser] stays 0 until that unit is granted.
- Back-to-back refill: unit 2 is valid for 4 consecutive cycles with tags 5, 6, 7, 8 and the other units idle -> eu_ready[2] stays 1 and 4 consecutive cdb_valid cycles carry tags 5 to 8.
- Stall: cdb_stall=1 for 5 cycles while each unit delivers one result -> no cdb_valid pulses and eu_ready=3'b000. After release, 3 broadcasts follow on consecutive cycles.
- Flush: slots hold tags 1 and 2, flush=1 for one cycle while unit 2 offers tag 9 -> no broadcast of 1, 2 or 9; eu_ready=3'b111 afterwards; bcast_cnt is unchanged.
- Reset and saturation:
  - Assert rst while slots are full -> all outputs return to their reset values in the next cycle.
  - Force 65,536 broadcasts -> bcast_cnt reads 16'hFFFF and holds.
